// File: rtl/valid_opcode.sv
// Opcode legality decoder: combinational valid plus a registered decode (1-cycle latency)
// and saturating legal/illegal sample counters; all state holds while in_en is low.
module valid_opcode (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_en,
   input  logic [5:0]  opcode,
   output logic        valid,
   output logic        valid_q,
   output logic [3:0]  op_idx_q,
   output logic        unary_q,
   output logic [15:0] valid_cnt,
   output logic [15:0] invalid_cnt
);

   logic        w_valid;
   logic [3:0]  w_op_idx;
   logic        w_unary;

   logic        r_valid_q;
   logic [3:0]  r_op_idx_q;
   logic        r_unary_q;
   logic [15:0] r_valid_cnt;
   logic [15:0] r_invalid_cnt;

   // Full 6-bit match: anything above 0x0F falls into the default arm.
   always_comb begin
      w_valid  = 1'b1;
      w_op_idx = 4'hF;
      w_unary  = 1'b0;
      case (opcode)
         6'h06:   w_op_idx = 4'd0;
         6'h08:   w_op_idx = 4'd1;
         6'h0A: begin
            w_op_idx = 4'd2;
            w_unary  = 1'b1;
         end
         6'h0C: begin
            w_op_idx = 4'd3;
            w_unary  = 1'b1;
         end
         6'h0E:   w_op_idx = 4'd4;
         6'h0B:   w_op_idx = 4'd5;
         6'h0D:   w_op_idx = 4'd6;
         6'h0F: begin
            w_op_idx = 4'd7;
            w_unary  = 1'b1;
         end
         6'h02:   w_op_idx = 4'd8;
         6'h03:   w_op_idx = 4'd9;
         6'h09:   w_op_idx = 4'd10;
         default: w_valid  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid_q     <= 1'b0;
         r_op_idx_q    <= 4'hF;
         r_unary_q     <= 1'b0;
         r_valid_cnt   <= 16'h0000;
         r_invalid_cnt <= 16'h0000;
      end else if (in_en) begin
         r_valid_q  <= w_valid;
         r_op_idx_q <= w_op_idx;
         r_unary_q  <= w_unary;
         // Counters stick at all-ones rather than wrapping.
         if (w_valid) begin
            if (r_valid_cnt != 16'hFFFF)
               r_valid_cnt <= r_valid_cnt + 16'd1;
         end else begin
            if (r_invalid_cnt != 16'hFFFF)
               r_invalid_cnt <= r_invalid_cnt + 16'd1;
         end
      end
   end

   assign valid       = w_valid;
   assign valid_q     = r_valid_q;
   assign op_idx_q    = r_op_idx_q;
   assign unary_q     = r_unary_q;
   assign valid_cnt   = r_valid_cnt;
   assign invalid_cnt = r_invalid_cnt;

endmodule

// File: tb/tb_valid_opcode.sv
// Directed bench for valid_opcode: inputs change on the falling edge, outputs are
// checked 1 ns after the rising edge (or mid-cycle for the combinational valid).
module tb_valid_opcode;

   logic        clk;
   logic        rst;
   logic        in_en;
   logic [5:0]  opcode;
   logic        valid;
   logic        valid_q;
   logic [3:0]  op_idx_q;
   logic        unary_q;
   logic [15:0] valid_cnt;
   logic [15:0] invalid_cnt;

   int total = 0;
   int bad   = 0;

   valid_opcode dut (
      .clk         (clk),
      .rst         (rst),
      .in_en       (in_en),
      .opcode      (opcode),
      .valid       (valid),
      .valid_q     (valid_q),
      .op_idx_q    (op_idx_q),
      .unary_q     (unary_q),
      .valid_cnt   (valid_cnt),
      .invalid_cnt (invalid_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present inputs on the falling edge, then land just after the next rising edge.
   task automatic step(input logic r, input logic en, input logic [5:0] op);
      @(negedge clk);
      rst    = r;
      in_en  = en;
      opcode = op;
      @(posedge clk);
      #1;
   endtask

   // Operation table for opcodes 0x00..0x3F; idx 4'hF marks illegal.
   function automatic logic [3:0] exp_idx(input logic [5:0] op);
      case (op)
         6'h06: return 4'd0;
         6'h08: return 4'd1;
         6'h0A: return 4'd2;
         6'h0C: return 4'd3;
         6'h0E: return 4'd4;
         6'h0B: return 4'd5;
         6'h0D: return 4'd6;
         6'h0F: return 4'd7;
         6'h02: return 4'd8;
         6'h03: return 4'd9;
         6'h09: return 4'd10;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic exp_unary(input logic [5:0] op);
      return (op == 6'h0A) || (op == 6'h0C) || (op == 6'h0F);
   endfunction

   initial begin
      logic [31:0] instr;
      int          legal_seen;

      rst = 1'b1; in_en = 1'b0; opcode = 6'h00;
      step(1'b1, 1'b0, 6'h00);
      step(1'b1, 1'b0, 6'h00);
      check("rst_valid_q",     {15'd0, valid_q}, 16'd0);
      check("rst_op_idx_q",    {12'd0, op_idx_q}, 16'h000F);
      check("rst_unary_q",     {15'd0, unary_q}, 16'd0);
      check("rst_valid_cnt",   valid_cnt, 16'd0);
      check("rst_invalid_cnt", invalid_cnt, 16'd0);

      // valid ignores rst
      @(negedge clk);
      opcode = 6'h06;
      #1 check("valid_during_rst", {15'd0, valid}, 16'd1);

      // Instruction 0x00142006 carries opcode 0x06 in its low six bits.
      instr = 32'h0014_2006;
      @(negedge clk);
      rst = 1'b0; in_en = 1'b0; opcode = instr[5:0];
      #1 check("add_valid_comb", {15'd0, valid}, 16'd1);
      check("add_hold_before_en", {12'd0, op_idx_q}, 16'h000F);
      step(1'b0, 1'b1, instr[5:0]);
      check("add_valid_q",   {15'd0, valid_q}, 16'd1);
      check("add_op_idx_q",  {12'd0, op_idx_q}, 16'd0);
      check("add_unary_q",   {15'd0, unary_q}, 16'd0);
      check("add_valid_cnt", valid_cnt, 16'd1);

      // Full sweep from a clean reset.
      step(1'b1, 1'b0, 6'h00);
      legal_seen = 0;
      for (int op = 0; op < 64; op++) begin
         @(negedge clk);
         rst = 1'b0; in_en = 1'b1; opcode = op[5:0];
         #1 check($sformatf("sweep_valid_%02h", op), {15'd0, valid},
                  {15'd0, (exp_idx(op[5:0]) != 4'hF)});
         @(posedge clk);
         #1;
         check($sformatf("sweep_valid_q_%02h", op), {15'd0, valid_q},
               {15'd0, (exp_idx(op[5:0]) != 4'hF)});
         check($sformatf("sweep_idx_%02h", op), {12'd0, op_idx_q}, {12'd0, exp_idx(op[5:0])});
         check($sformatf("sweep_unary_%02h", op), {15'd0, unary_q}, {15'd0, exp_unary(op[5:0])});
         if (valid_q === 1'b1) legal_seen++;
      end
      check("sweep_legal_seen",  legal_seen[15:0], 16'd11);
      check("sweep_valid_cnt",   valid_cnt, 16'd11);
      check("sweep_invalid_cnt", invalid_cnt, 16'd53);

      // 0x0C (neg, unary) then 0x1C (illegal: bit 4 must not be ignored).
      step(1'b0, 1'b1, 6'h0C);
      check("neg_op_idx_q", {12'd0, op_idx_q}, 16'd3);
      check("neg_unary_q",  {15'd0, unary_q}, 16'd1);
      check("neg_valid_cnt", valid_cnt, 16'd12);
      step(1'b0, 1'b1, 6'h1C);
      check("x1c_valid_q",     {15'd0, valid_q}, 16'd0);
      check("x1c_op_idx_q",    {12'd0, op_idx_q}, 16'h000F);
      check("x1c_unary_q",     {15'd0, unary_q}, 16'd0);
      check("x1c_invalid_cnt", invalid_cnt, 16'd54);
      check("x1c_valid_cnt",   valid_cnt, 16'd12);

      // Load a legal decode, then toggle with in_en low: only valid may move.
      step(1'b0, 1'b1, 6'h0F);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, (i % 2 == 0) ? 6'h04 : 6'h02);
         check($sformatf("hold_valid_%0d", i), {15'd0, valid}, (i % 2 == 0) ? 16'd0 : 16'd1);
         check($sformatf("hold_valid_q_%0d", i), {15'd0, valid_q}, 16'd1);
         check($sformatf("hold_idx_%0d", i), {12'd0, op_idx_q}, 16'd7);
         check($sformatf("hold_unary_%0d", i), {15'd0, unary_q}, 16'd1);
         check($sformatf("hold_vcnt_%0d", i), valid_cnt, 16'd13);
         check($sformatf("hold_icnt_%0d", i), invalid_cnt, 16'd54);
      end

      // Reset beats a simultaneous legal sample.
      step(1'b1, 1'b1, 6'h09);
      check("rstpri_valid_q",     {15'd0, valid_q}, 16'd0);
      check("rstpri_op_idx_q",    {12'd0, op_idx_q}, 16'h000F);
      check("rstpri_unary_q",     {15'd0, unary_q}, 16'd0);
      check("rstpri_valid_cnt",   valid_cnt, 16'd0);
      check("rstpri_invalid_cnt", invalid_cnt, 16'd0);
      check("rstpri_valid_comb",  {15'd0, valid}, 16'd1);
      step(1'b0, 1'b0, 6'h0A);
      step(1'b0, 1'b0, 6'h0A);
      check("postrst_hold_idx", {12'd0, op_idx_q}, 16'h000F);
      check("postrst_hold_vq",  {15'd0, valid_q}, 16'd0);
      step(1'b0, 1'b1, 6'h0A);
      check("postrst_first_idx",   {12'd0, op_idx_q}, 16'd2);
      check("postrst_first_unary", {15'd0, unary_q}, 16'd1);

      // Saturation: 65537 illegal samples from reset.
      step(1'b1, 1'b0, 6'h3F);
      @(negedge clk);
      rst = 1'b0; in_en = 1'b1; opcode = 6'h3F;
      repeat (65534) @(posedge clk);
      #1 check("sat_pre_invalid_cnt", invalid_cnt, 16'hFFFE);
      repeat (3) @(posedge clk);
      #1;
      check("sat_invalid_cnt", invalid_cnt, 16'hFFFF);
      check("sat_valid_cnt",   valid_cnt, 16'd0);
      check("sat_op_idx_q",    {12'd0, op_idx_q}, 16'h000F);
      @(negedge clk);
      in_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/valid_opcode.md
VALID_OPCODE -- requirements
Module: valid_opcode

Interface
REQ-001 clk  input  1  — single clock; all state updates on rising edge.
REQ-002 rst  input  1  — reset, synchronous, active-high.
REQ-003 in_en  input  1  — sample strobe; opcode is captured and counted only when high.
REQ-004 opcode  input  6  — instruction bits [5:0].
REQ-005 valid  output  1  — combinational: 1 iff opcode is in the legal set.
REQ-006 valid_q  output  1  — registered copy of valid.
REQ-007 op_idx_q  output  4  — registered operation index; 4'hF when the opcode is illegal.
REQ-008 unary_q  output  1  — registered; 1 when the operation uses operand a only.
REQ-009 valid_cnt  output  16  — count of legal opcodes sampled.
REQ-010 invalid_cnt  output  16  — count of illegal opcodes sampled.

Function
REQ-011 The legal set SHALL be exactly opcodes 0x02, 0x03, 0x06, 0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0D, 0x0E and 0x0F.
REQ-012 All other opcodes SHALL be illegal: 0x00, 0x01, 0x04, 0x05, 0x07 and 0x10–0x3F.
REQ-013 The legal-set comparison SHALL use all 6 bits; no bits are truncated or ignored.
REQ-014 valid SHALL be purely combinational from opcode, with zero latency.
REQ-015 valid SHALL NOT depend on rst or in_en.
REQ-016 The index mapping SHALL be: 0x06 add=0, 0x08 sub=1, 0x0A abs=2, 0x0C neg=3, 0x0E max=4, 0x0B min=5, 0x0D avg=6, 0x0F not=7, 0x02 or=8, 0x03 and=9, 0x09 xor=10.
REQ-017 unary SHALL be 1 only for opcodes 0x0A, 0x0C and 0x0F.
REQ-018 unary SHALL be 0 for every other opcode, legal or illegal.
REQ-019 On a clk edge with in_en=1 and rst=0, valid_q, op_idx_q and unary_q SHALL load the decode of the current opcode (1-cycle latency).
REQ-020 On a clk edge with in_en=0 and rst=0, all registered outputs and both counters SHALL hold their values.
REQ-021 On each in_en=1 sample, valid_cnt SHALL increment if the opcode is legal; otherwise invalid_cnt SHALL increment.
REQ-022 Exactly one counter SHALL change per sample.
REQ-023 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-024 Registered outputs SHALL change only on clk rising edges.
REQ-025 An opcode change between edges SHALL affect valid immediately and the registered outputs only at the next sampled edge.

Reset
REQ-026 When rst=1 at a clk edge, the block SHALL set valid_q=0, op_idx_q=4'hF, unary_q=0, valid_cnt=0 and invalid_cnt=0.
REQ-027 rst SHALL take priority over in_en.
REQ-028 A sample presented in the same cycle as rst SHALL be discarded and not counted.
REQ-029 Registered outputs SHALL hold their reset values until the first in_en=1 edge after rst deasserts.

Verification
REQ-030 Scenario: reset, then opcode=0x06 (instruction 0x00142006) with in_en=1 for one edge -> valid=1 immediately; after the edge valid_q=1, op_idx_q=0, unary_q=0, valid_cnt=1.
REQ-031 Scenario: sweep all 64 opcodes with in_en=1 -> valid_q=1 exactly for the 11 legal codes, with indices per REQ-016; at end valid_cnt=11, invalid_cnt=53.
REQ-032 Scenario: opcode=0x0C, then 0x1C -> first gives op_idx_q=3, unary_q=1; second gives valid_q=0, op_idx_q=0xF, unary_q=0, invalid_cnt+1.
REQ-033 Scenario: in_en=0 for 5 cycles while opcode toggles 0x02/0x04 -> valid follows the opcode; registered outputs and counters are unchanged.
REQ-034 Scenario: rst=1 and in_en=1 with opcode=0x09 on the same edge -> all outputs take their reset values and neither counter increments.
REQ-035 Scenario: 65537 samples of opcode 0x3F -> invalid_cnt=0xFFFF (saturated) and valid_cnt=0.
